dsc_mul_nary: RTL and testbench

- Parametrised deterministic stochastic-computing (DSC) multiplier: the product of NUM_INPUTS unsigned operands of NUM_BITS each.
- Uses the clock-division method. Each operand's unary bitstream is generated against its own NUM_BITS-wide digit of one shared NUM_INPUTS*NUM_BITS-bit cycle counter.
- The streams are ANDed together and the ANDed stream is accumulated into a binary count.
- Generalises the fixed 2-input 4-bit dsc_mul with:
  - a start/busy/done handshake,
  - operand latching,
  - an optional zero-operand early termination,
  - an on-chip cycle counter for latency measurement.

---
 rtl/dsc_mul_nary.sv | 129 ++++++++++++
 tb/tb_dsc_mul_nary.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/dsc_mul_nary.sv
// Deterministic stochastic-computing multiplier of NUM_INPUTS operands (clock-division method).
// Operands stream as unary bits against digits of a shared counter; the ANDed stream is counted.
module dsc_mul_nary #(
    parameter int NUM_INPUTS = 2,
    parameter int NUM_BITS   = 4,
    parameter int EARLY_TERM = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             en,
    input  logic                             start,
    input  logic [NUM_INPUTS*NUM_BITS-1:0]   a,
    output logic [NUM_INPUTS*NUM_BITS-1:0]   z,
    output logic                             busy,
    output logic                             done,
    output logic [NUM_INPUTS*NUM_BITS:0]     cycles
);
    localparam int TW = NUM_INPUTS * NUM_BITS;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [TW-1:0] CNT_ONE = 1;
    localparam logic [TW:0]   CYC_ONE = 1;

    logic [1:0]    state_q, state_d;
    logic [TW-1:0] ops_q, ops_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] acc_q, acc_d;
    logic [TW-1:0] z_q, z_d;
    logic [TW:0]   cycles_q, cycles_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic          stream_and;
    logic          any_zero;
    logic [TW-1:0] acc_next;

    // Each operand is compared against its own digit of the shared counter.
    always_comb begin
        stream_and = 1'b1;
        any_zero   = 1'b0;
        for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
            if (ops_q[i*NUM_BITS +: NUM_BITS] <= cnt_q[i*NUM_BITS +: NUM_BITS])
                stream_and = 1'b0;
            if (a[i*NUM_BITS +: NUM_BITS] == '0)
                any_zero = 1'b1;
        end
        acc_next = acc_q + {{(TW-1){1'b0}}, stream_and};
    end

    always_comb begin
        state_d  = state_q;
        ops_d    = ops_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        z_d      = z_q;
        cycles_d = cycles_q;
        busy_d   = busy_q;
        done_d   = done_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    ops_d    = a;
                    cnt_d    = '0;
                    acc_d    = '0;
                    cycles_d = '0;
                    z_d      = '0;
                    done_d   = 1'b0;
                    if ((EARLY_TERM != 0) && any_zero) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_RUN;
                        busy_d  = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (en) begin
                    acc_d    = acc_next;
                    cnt_d    = cnt_q + CNT_ONE;
                    cycles_d = cycles_q + CYC_ONE;
                    // The all-ones count is the final stream bit; exit before the counter wraps.
                    if (cnt_q == '1) begin
                        z_d     = acc_next;
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            ops_q    <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            z_q      <= '0;
            cycles_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ops_q    <= ops_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            z_q      <= z_d;
            cycles_q <= cycles_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign z      = z_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign cycles = cycles_q;

endmodule

// File: tb/tb_dsc_mul_nary.sv
// Scoreboard bench for dsc_mul_nary: stimulus pushes expected {z, cycles}, monitors pop on each completion.
module tb_dsc_mul_nary;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // u0: N=2 W=4 early-term; u1: N=2 W=4 no early-term; u2: N=3 W=2 early-term
    logic       en0 = 1'b1, start0 = 1'b0, busy0, done0;
    logic [7:0] a0 = '0, z0;
    logic [8:0] cyc0;
    logic       en1 = 1'b1, start1 = 1'b0, busy1, done1;
    logic [7:0] a1 = '0, z1;
    logic [8:0] cyc1;
    logic       en2 = 1'b1, start2 = 1'b0, busy2, done2;
    logic [5:0] a2 = '0, z2;
    logic [6:0] cyc2;

    dsc_mul_nary #(.NUM_INPUTS(2), .NUM_BITS(4), .EARLY_TERM(1)) u0 (
        .clk(clk), .rst(rst), .en(en0), .start(start0), .a(a0),
        .z(z0), .busy(busy0), .done(done0), .cycles(cyc0));
    dsc_mul_nary #(.NUM_INPUTS(2), .NUM_BITS(4), .EARLY_TERM(0)) u1 (
        .clk(clk), .rst(rst), .en(en1), .start(start1), .a(a1),
        .z(z1), .busy(busy1), .done(done1), .cycles(cyc1));
    dsc_mul_nary #(.NUM_INPUTS(3), .NUM_BITS(2), .EARLY_TERM(1)) u2 (
        .clk(clk), .rst(rst), .en(en2), .start(start2), .a(a2),
        .z(z2), .busy(busy2), .done(done2), .cycles(cyc2));

    int passes = 0;
    int total  = 0;

    longint q0_z[$], q0_c[$], q1_z[$], q1_c[$], q2_z[$], q2_c[$];

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic note_fail(input string name);
        total++;
        $display("FAIL %s", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitors: a completion is done rising, or done staying high across an accepted start.
    logic m0_acc, m0_dp, m0_rs, m1_acc, m1_dp, m1_rs, m2_acc, m2_dp, m2_rs;
    longint m0_ez, m0_ec, m1_ez, m1_ec, m2_ez, m2_ec;

    always @(posedge clk) begin
        m0_acc = start0 && !busy0; m0_dp = done0; m0_rs = rst;
        #1;
        if (!m0_rs && done0 === 1'b1 && (m0_dp !== 1'b1 || m0_acc)) begin
            if (q0_z.size() == 0) note_fail("u0 unexpected done");
            else begin
                m0_ez = q0_z.pop_front(); m0_ec = q0_c.pop_front();
                chk("u0 z", z0, m0_ez);
                chk("u0 cycles", cyc0, m0_ec);
            end
        end
    end

    always @(posedge clk) begin
        m1_acc = start1 && !busy1; m1_dp = done1; m1_rs = rst;
        #1;
        if (!m1_rs && done1 === 1'b1 && (m1_dp !== 1'b1 || m1_acc)) begin
            if (q1_z.size() == 0) note_fail("u1 unexpected done");
            else begin
                m1_ez = q1_z.pop_front(); m1_ec = q1_c.pop_front();
                chk("u1 z", z1, m1_ez);
                chk("u1 cycles", cyc1, m1_ec);
            end
        end
    end

    always @(posedge clk) begin
        m2_acc = start2 && !busy2; m2_dp = done2; m2_rs = rst;
        #1;
        if (!m2_rs && done2 === 1'b1 && (m2_dp !== 1'b1 || m2_acc)) begin
            if (q2_z.size() == 0) note_fail("u2 unexpected done");
            else begin
                m2_ez = q2_z.pop_front(); m2_ec = q2_c.pop_front();
                chk("u2 z", z2, m2_ez);
                chk("u2 cycles", cyc2, m2_ec);
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Issue a start on u0 and return ticks from the accepting edge until done (bounded).
    task automatic u0_run(input logic [7:0] ops, input int bound, output int n);
        a0 = ops; start0 = 1'b1;
        tick();
        start0 = 1'b0;
        n = 0;
        while (!done0 && n < bound) begin tick(); n++; end
        if (!done0) note_fail("u0 done timeout");
    endtask

    initial begin
        int n, busy_cnt, sum_cyc, ops_cnt;
        logic [5:0] r;
        longint prod;

        repeat (3) tick();
        rst = 1'b0;
        chk("reset z", z0, 0);
        chk("reset busy", busy0, 0);
        chk("reset done", done0, 0);
        chk("reset cycles", cyc0, 0);

        // 15*15, with busy width measurement
        q0_z.push_back(225); q0_c.push_back(256);
        a0 = {4'd15, 4'd15}; start0 = 1'b1;
        tick();
        start0 = 1'b0;
        busy_cnt = busy0 ? 1 : 0;
        n = 0;
        while (!done0 && n < 1000) begin tick(); n++; if (busy0) busy_cnt++; end
        chk("15x15 latency", n, 256);
        chk("15x15 busy cycles", busy_cnt, 256);
        repeat (20) tick();
        chk("15x15 z hold", z0, 225);
        chk("15x15 done hold", done0, 1);

        // zero operand, early termination
        q0_z.push_back(0); q0_c.push_back(0);
        a0 = {4'd0, 4'd9}; start0 = 1'b1;
        tick();
        start0 = 1'b0;
        chk("early-term done", done0, 1);
        chk("early-term busy", busy0, 0);
        tick();

        // zero operand without early termination runs the full length
        q1_z.push_back(0); q1_c.push_back(256);
        a1 = {4'd0, 4'd9}; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        n = 0;
        while (!done1 && n < 1000) begin tick(); n++; end
        chk("no-early-term latency", n, 256);

        // 7*11 with a 10-cycle en gap
        q0_z.push_back(77); q0_c.push_back(256);
        a0 = {4'd7, 4'd11}; start0 = 1'b1;
        tick();
        start0 = 1'b0;
        n = 0;
        repeat (50) begin tick(); n++; end
        en0 = 1'b0;
        repeat (10) begin tick(); n++; end
        chk("en gap cycles frozen", cyc0, 50);
        chk("en gap busy held", busy0, 1);
        en0 = 1'b1;
        while (!done0 && n < 1000) begin tick(); n++; end
        chk("en gap latency", n, 266);

        // start during RUN is ignored
        q0_z.push_back(30); q0_c.push_back(256);
        a0 = {4'd5, 4'd6}; start0 = 1'b1;
        tick();
        start0 = 1'b0;
        n = 0;
        repeat (99) begin tick(); n++; end
        a0 = {4'd1, 4'd1}; start0 = 1'b1;
        tick(); n++;
        start0 = 1'b0;
        while (!done0 && n < 1000) begin tick(); n++; end
        chk("ignored start latency", n, 256);

        // start from DONE: done drops on the accepting edge
        q0_z.push_back(12); q0_c.push_back(256);
        a0 = {4'd3, 4'd4}; start0 = 1'b1;
        tick();
        start0 = 1'b0;
        chk("restart done drop", done0, 0);
        chk("restart busy", busy0, 1);
        n = 0;
        while (!done0 && n < 1000) begin tick(); n++; end
        chk("restart latency", n, 256);

        // reset mid-RUN aborts with no result
        a0 = {4'd9, 4'd9}; start0 = 1'b1;
        tick();
        start0 = 1'b0;
        repeat (50) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid-run rst z", z0, 0);
        chk("mid-run rst cycles", cyc0, 0);
        chk("mid-run rst busy", busy0, 0);
        chk("mid-run rst done", done0, 0);
        q0_z.push_back(6); q0_c.push_back(256);
        u0_run({4'd2, 4'd3}, 1000, n);
        chk("post-rst latency", n, 256);

        // N=3 W=2 randomised operand sets against a bench-side product
        sum_cyc = 0;
        ops_cnt = 300;
        for (int k = 0; k < ops_cnt; k++) begin
            r = 6'($urandom);
            prod = longint'(r[1:0]) * longint'(r[3:2]) * longint'(r[5:4]);
            q2_z.push_back(prod);
            q2_c.push_back((r[1:0] == 0 || r[3:2] == 0 || r[5:4] == 0) ? 0 : 64);
            a2 = r; start2 = 1'b1;
            tick();
            start2 = 1'b0;
            n = 0;
            while (!done2 && n < 200) begin tick(); n++; end
            if (!done2) note_fail("u2 done timeout");
            sum_cyc += int'(cyc2);
        end
        $display("u2 average cycle count: %0.2f", real'(sum_cyc) / real'(ops_cnt));

        repeat (3) tick();
        chk("u0 scoreboard drained", q0_z.size(), 0);
        chk("u1 scoreboard drained", q1_z.size(), 0);
        chk("u2 scoreboard drained", q2_z.size(), 0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
